// File: rtl/nios2_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug scan master.
// Holds the scan FSM encoding and the debug-slave IR codes.
package nios2_debug_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RESP
   } scan_state_e;

   localparam logic [1:0] IR_MONITOR   = 2'b00;
   localparam logic [1:0] IR_BREAK     = 2'b01;
   localparam logic [1:0] IR_TRACEMEM  = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   localparam int DR_WIDTH = 38;

endpackage

// File: rtl/nios2_debug_scan_tick.sv
// Virtual TCK divider: one tck_en strobe every DIV clocks while running.
// The count restarts from zero whenever the scan is idle or a tick fires.
module nios2_debug_scan_tick
   import nios2_debug_scan_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic run_i,
   output logic tck_en_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tck_en_o = run_i && (cnt_q == LAST);

   // Next count: wrap on every tick, since state changes only happen there.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!run_i || tck_en_o) begin
         cnt_d = '0;
      end
   end

   // Divider count register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nios2_debug_scan_master.sv
// Host-side virtual-JTAG scan initiator for the Nios II debug slave.
// Replays each command as UIR, CDR, LSB-first SDR, UDR, RTI, then responds.
module nios2_debug_scan_master
   import nios2_debug_scan_pkg::*;
#(
   parameter int DR_W = DR_WIDTH,
   parameter int IR_W = 2,
   parameter int DIV  = 1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [IR_W-1:0] cmd_ir_i,
   input  logic [DR_W-1:0] cmd_dr_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DR_W-1:0] rsp_dr_o,
   output logic [IR_W-1:0] rsp_ir_o,
   output logic            tck_en_o,
   output logic [IR_W-1:0] ir_in_o,
   input  logic [IR_W-1:0] ir_out_i,
   output logic            tdi_o,
   input  logic            tdo_i,
   output logic            vs_uir_o,
   output logic            vs_cdr_o,
   output logic            vs_sdr_o,
   output logic            vs_udr_o,
   output logic            jtag_state_rti_o
);

   localparam int BW = $clog2(DR_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DR_W - 1);

   scan_state_e     state_q;
   logic [DR_W-1:0] sr_q;
   logic [BW-1:0]   bit_q;
   logic [IR_W-1:0] ir_q;
   logic [DR_W-1:0] rsp_dr_q;
   logic [IR_W-1:0] rsp_ir_q;
   logic            run;
   logic            tick;

   assign run = (state_q != ST_IDLE) && (state_q != ST_RESP);

   nios2_debug_scan_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .run_i    (run),
      .tck_en_o (tick)
   );

   // Scan sequencer: walks the JTAG states one tick at a time.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         sr_q     <= '0;
         bit_q    <= '0;
         ir_q     <= '0;
         rsp_dr_q <= '0;
         rsp_ir_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  ir_q    <= cmd_ir_i;
                  sr_q    <= cmd_dr_i;
                  bit_q   <= '0;
                  state_q <= ST_UIR;
               end
            end
            ST_UIR: begin
               if (tick) begin
                  rsp_ir_q <= ir_out_i;
                  state_q  <= ST_CDR;
               end
            end
            ST_CDR: begin
               if (tick) begin
                  state_q <= ST_SDR;
               end
            end
            ST_SDR: begin
               if (tick) begin
                  sr_q  <= {tdo_i, sr_q[DR_W-1:1]};
                  bit_q <= bit_q + 1'b1;
                  if (bit_q == LAST_BIT) begin
                     state_q <= ST_UDR;
                  end
               end
            end
            ST_UDR: begin
               if (tick) begin
                  state_q <= ST_RTI;
               end
            end
            ST_RTI: begin
               if (tick) begin
                  rsp_dr_q <= sr_q;
                  state_q  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o      = (state_q == ST_IDLE);
   assign rsp_valid_o      = (state_q == ST_RESP);
   assign rsp_dr_o         = rsp_dr_q;
   assign rsp_ir_o         = rsp_ir_q;
   assign tck_en_o         = tick;
   assign ir_in_o          = ir_q;
   assign tdi_o            = (state_q == ST_SDR) && sr_q[0];
   assign vs_uir_o         = (state_q == ST_UIR);
   assign vs_cdr_o         = (state_q == ST_CDR);
   assign vs_sdr_o         = (state_q == ST_SDR);
   assign vs_udr_o         = (state_q == ST_UDR);
   assign jtag_state_rti_o = (state_q == ST_RTI);

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Bench for nios2_debug_scan_master: DIV=1 and DIV=3 instances.
// A responder model supplies tdo and records shifted bits per tick.
module tb_nios2_debug_scan_master;

   localparam int DR_W = 38;
   localparam int IR_W = 2;
   localparam logic [DR_W-1:0] DR1 = 38'h2A_5555_AAAA;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_valid3 = 1'b0;
   logic            rsp_ready = 1'b1;
   logic            rsp_ready3 = 1'b1;
   logic [IR_W-1:0] cmd_ir = '0;
   logic [DR_W-1:0] cmd_dr = '0;
   logic [IR_W-1:0] ir_out = '0;
   logic            tdo;

   logic            cmd_ready, rsp_valid, tck_en, tdi;
   logic [DR_W-1:0] rsp_dr;
   logic [IR_W-1:0] rsp_ir, ir_in;
   logic            vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

   logic            cmd_ready3, rsp_valid3, tck_en3, tdi3;
   logic [DR_W-1:0] rsp_dr3;
   logic [IR_W-1:0] rsp_ir3, ir_in3;
   logic            vs_uir3, vs_cdr3, vs_sdr3, vs_udr3, rti3;

   nios2_debug_scan_master #(.DR_W(DR_W), .IR_W(IR_W), .DIV(1)) u_dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .cmd_valid_i      (cmd_valid),
      .cmd_ready_o      (cmd_ready),
      .cmd_ir_i         (cmd_ir),
      .cmd_dr_i         (cmd_dr),
      .rsp_valid_o      (rsp_valid),
      .rsp_ready_i      (rsp_ready),
      .rsp_dr_o         (rsp_dr),
      .rsp_ir_o         (rsp_ir),
      .tck_en_o         (tck_en),
      .ir_in_o          (ir_in),
      .ir_out_i         (ir_out),
      .tdi_o            (tdi),
      .tdo_i            (tdo),
      .vs_uir_o         (vs_uir),
      .vs_cdr_o         (vs_cdr),
      .vs_sdr_o         (vs_sdr),
      .vs_udr_o         (vs_udr),
      .jtag_state_rti_o (rti)
   );

   nios2_debug_scan_master #(.DR_W(DR_W), .IR_W(IR_W), .DIV(3)) u_dut3 (
      .clk_i            (clk),
      .reset_i          (reset),
      .cmd_valid_i      (cmd_valid3),
      .cmd_ready_o      (cmd_ready3),
      .cmd_ir_i         (cmd_ir),
      .cmd_dr_i         (cmd_dr),
      .rsp_valid_o      (rsp_valid3),
      .rsp_ready_i      (rsp_ready3),
      .rsp_dr_o         (rsp_dr3),
      .rsp_ir_o         (rsp_ir3),
      .tck_en_o         (tck_en3),
      .ir_in_o          (ir_in3),
      .ir_out_i         (ir_out),
      .tdi_o            (tdi3),
      .tdo_i            (tdo),
      .vs_uir_o         (vs_uir3),
      .vs_cdr_o         (vs_cdr3),
      .vs_sdr_o         (vs_sdr3),
      .vs_udr_o         (vs_udr3),
      .jtag_state_rti_o (rti3)
   );

   // Responder: 0 = tdi looped through a one-tick delay, 1 = constant 1, 2 = random
   logic [1:0] mode = 2'd0;
   logic dly = 1'b0;
   logic rnd = 1'b0;
   logic tick_seen = 1'b0;
   logic tdi_seen = 1'b0;
   assign tdo = (mode == 2'd0) ? dly : (mode == 2'd1) ? 1'b1 : rnd;

   int cyc_g = 0;
   int n_tck = 0, n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
   int n_irbad = 0;
   logic [IR_W-1:0] exp_ir = '0;
   logic tdo_q[$];
   logic tdi_q[$];
   int t3_q[$];

   int n_pass = 0;
   int n_total = 0;

   always @(posedge clk) begin
      cyc_g <= cyc_g + 1;
      rnd <= 1'($urandom);
      if (reset) dly <= 1'b0;
      else if (tick_seen) dly <= tdi_seen;
   end

   // Observe everything mid-cycle, ahead of the edge that acts on it
   always @(negedge clk) begin
      tick_seen <= tck_en;
      tdi_seen <= tdi;
      if (tck_en) n_tck++;
      if (vs_uir) n_uir++;
      if (vs_cdr) n_cdr++;
      if (vs_sdr) n_sdr++;
      if (vs_udr) n_udr++;
      if (rti) n_rti++;
      if (!cmd_ready && ir_in !== exp_ir) n_irbad++;
      if (tck_en && vs_sdr) begin
         tdo_q.push_back(tdo);
         tdi_q.push_back(tdi);
      end
      if (tck_en3) t3_q.push_back(cyc_g);
   end

   task automatic start_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr);
      cmd_ir = ir;
      cmd_dr = dr;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int c);
      c = 1;
      while (rsp_valid !== 1'b1 && c < 400) begin
         @(posedge clk); #1;
         c++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      n_total++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
      else n_pass++;
      n_total++;
      if ({rsp_valid, tck_en, tdi} !== 3'b000)
         $display("FAIL reset_strobes got %b want 000", {rsp_valid, tck_en, tdi});
      else n_pass++;
      n_total++;
      if ({vs_uir, vs_cdr, vs_sdr, vs_udr, rti} !== 5'b0)
         $display("FAIL reset_vs got %b want 00000", {vs_uir, vs_cdr, vs_sdr, vs_udr, rti});
      else n_pass++;
      n_total++;
      if ({ir_in, rsp_ir, rsp_dr} !== '0)
         $display("FAIL reset_regs got ir_in=%h rsp_ir=%h rsp_dr=%h want 0", ir_in, rsp_ir, rsp_dr);
      else n_pass++;
      n_total++;
      if ({cmd_ready3, rsp_valid3, tck_en3} !== 3'b100)
         $display("FAIL reset_div3 got %b want 100", {cmd_ready3, rsp_valid3, tck_en3});
      else n_pass++;
   endtask

   task automatic test_loopback();
      int c, sd;
      logic [DR_W-1:0] e, w;
      mode = 2'd0;
      rsp_ready = 1'b1;
      ir_out = 2'b01;
      sd = tdi_q.size();
      start_cmd(2'b00, DR1);
      wait_rsp(c);
      n_total++;
      if (c != 43) $display("FAIL loop_latency got %0d want 43", c);
      else n_pass++;
      e = DR1 << 1;
      n_total++;
      if (rsp_dr !== e) $display("FAIL loop_rsp_dr got %h want %h", rsp_dr, e);
      else n_pass++;
      w = '0;
      for (int k = 0; k < DR_W; k++)
         if (sd + k < tdi_q.size()) w[k] = tdi_q[sd + k];
      n_total++;
      if (w !== DR1) $display("FAIL loop_tdi_bits got %h want %h", w, DR1);
      else n_pass++;
      n_total++;
      if (rsp_ir !== 2'b01) $display("FAIL loop_rsp_ir got %b want 01", rsp_ir);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (cmd_ready !== 1'b1) $display("FAIL loop_back_idle got %b want 1", cmd_ready);
      else n_pass++;
   endtask

   task automatic test_tdo_high();
      int c, t0, u0, c0, s0, d0, r0, b0;
      mode = 2'd1;
      rsp_ready = 1'b1;
      ir_out = 2'b10;
      exp_ir = 2'b11;
      t0 = n_tck; u0 = n_uir; c0 = n_cdr; s0 = n_sdr; d0 = n_udr; r0 = n_rti;
      b0 = n_irbad;
      start_cmd(2'b11, 38'($urandom));
      wait_rsp(c);
      n_total++;
      if (rsp_dr !== {DR_W{1'b1}}) $display("FAIL ones_rsp_dr got %h want all ones", rsp_dr);
      else n_pass++;
      n_total++;
      if (rsp_ir !== 2'b10) $display("FAIL ones_rsp_ir got %b want 10", rsp_ir);
      else n_pass++;
      n_total++;
      if (n_irbad - b0 != 0) $display("FAIL ones_ir_in_stable got %0d bad cycles want 0", n_irbad - b0);
      else n_pass++;
      n_total++;
      if ({n_uir - u0, n_cdr - c0, n_udr - d0, n_rti - r0} != {32'd1, 32'd1, 32'd1, 32'd1})
         $display("FAIL ones_state_cycles got uir=%0d cdr=%0d udr=%0d rti=%0d want 1 each",
                  n_uir - u0, n_cdr - c0, n_udr - d0, n_rti - r0);
      else n_pass++;
      n_total++;
      if (n_sdr - s0 != DR_W) $display("FAIL ones_sdr_cycles got %0d want %0d", n_sdr - s0, DR_W);
      else n_pass++;
      n_total++;
      if (n_tck - t0 != DR_W + 4) $display("FAIL ones_tck_count got %0d want %0d", n_tck - t0, DR_W + 4);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_div3();
      int c, s, bad;
      mode = 2'd1;
      rsp_ready3 = 1'b1;
      s = t3_q.size();
      cmd_ir = 2'b01;
      cmd_dr = 38'($urandom);
      cmd_valid3 = 1'b1;
      @(posedge clk); #1;
      cmd_valid3 = 1'b0;
      c = 1;
      while (rsp_valid3 !== 1'b1 && c < 400) begin
         @(posedge clk); #1;
         c++;
      end
      n_total++;
      if (c != 127) $display("FAIL div3_latency got %0d want 127", c);
      else n_pass++;
      n_total++;
      if (rsp_dr3 !== {DR_W{1'b1}}) $display("FAIL div3_rsp_dr got %h want all ones", rsp_dr3);
      else n_pass++;
      n_total++;
      if (t3_q.size() - s != 42) $display("FAIL div3_tck_count got %0d want 42", t3_q.size() - s);
      else n_pass++;
      bad = 0;
      for (int k = s + 1; k < t3_q.size(); k++)
         if (t3_q[k] - t3_q[k-1] != 3) bad++;
      n_total++;
      if (bad != 0) $display("FAIL div3_spacing got %0d bad gaps want 0", bad);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_rsp_hold();
      int c, s, bad;
      logic [DR_W-1:0] d0, e;
      logic [IR_W-1:0] ir_b;
      mode = 2'd2;
      rsp_ready = 1'b0;
      s = tdo_q.size();
      start_cmd(2'b01, 38'({$urandom, $urandom}));
      wait_rsp(c);
      d0 = rsp_dr;
      e = '0;
      for (int k = 0; k < DR_W; k++)
         if (s + k < tdo_q.size()) e[k] = tdo_q[s + k];
      n_total++;
      if (d0 !== e) $display("FAIL hold_rsp_dr got %h want %h", d0, e);
      else n_pass++;
      ir_b = 2'b10;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            cmd_ir = ir_b;
            cmd_dr = 38'({$urandom, $urandom});
            cmd_valid = 1'b1;
         end
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_dr !== d0 || cmd_ready !== 1'b0) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad);
      else n_pass++;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if ({cmd_ready, rsp_valid} !== 2'b10)
         $display("FAIL hold_after_hs got ready,valid=%b want 10", {cmd_ready, rsp_valid});
      else n_pass++;
      s = tdo_q.size();
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n_total++;
      if ({vs_uir, ir_in} !== {1'b1, ir_b})
         $display("FAIL hold_second_accept got uir=%b ir_in=%b want 1 %b", vs_uir, ir_in, ir_b);
      else n_pass++;
      wait_rsp(c);
      e = '0;
      for (int k = 0; k < DR_W; k++)
         if (s + k < tdo_q.size()) e[k] = tdo_q[s + k];
      n_total++;
      if (c != 43 || rsp_dr !== e)
         $display("FAIL hold_second_rsp got cyc=%0d dr=%h want 43 %h", c, rsp_dr, e);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int c, s, k, bad;
      logic [DR_W-1:0] e;
      mode = 2'd2;
      rsp_ready = 1'b1;
      s = tdi_q.size();
      start_cmd(2'b11, 38'({$urandom, $urandom}));
      k = 0;
      while (tdi_q.size() - s < 17 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      n_total++;
      if (vs_sdr !== 1'b1 || tdi_q.size() - s != 17)
         $display("FAIL rst_mid_reach got sdr=%b bits=%0d want 1 17", vs_sdr, tdi_q.size() - s);
      else n_pass++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_total++;
      if ({cmd_ready, rsp_valid, tck_en, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, rti} !== 9'b1_0000_0000)
         $display("FAIL rst_mid_ctrl got %b want 100000000",
                  {cmd_ready, rsp_valid, tck_en, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, rti});
      else n_pass++;
      n_total++;
      if ({ir_in, rsp_ir, rsp_dr} !== '0)
         $display("FAIL rst_mid_regs got ir_in=%h rsp_ir=%h rsp_dr=%h want 0", ir_in, rsp_ir, rsp_dr);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL rst_mid_no_rsp got %0d bad cycles want 0", bad);
      else n_pass++;
      s = tdo_q.size();
      start_cmd(2'b00, 38'({$urandom, $urandom}));
      wait_rsp(c);
      e = '0;
      for (int j = 0; j < DR_W; j++)
         if (s + j < tdo_q.size()) e[j] = tdo_q[s + j];
      n_total++;
      if (c != 43 || rsp_dr !== e)
         $display("FAIL rst_mid_recover got cyc=%0d dr=%h want 43 %h", c, rsp_dr, e);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int c, s, t0;
      logic [DR_W-1:0] dr, e, w;
      logic [IR_W-1:0] ir, io;
      mode = 2'd2;
      for (int it = 0; it < 8; it++) begin
         dr = 38'({$urandom, $urandom});
         ir = 2'($urandom);
         io = 2'($urandom);
         ir_out = io;
         rsp_ready = 1'b0;
         s = tdo_q.size();
         t0 = n_tck;
         start_cmd(ir, dr);
         wait_rsp(c);
         e = '0;
         w = '0;
         for (int k = 0; k < DR_W; k++) begin
            if (s + k < tdo_q.size()) e[k] = tdo_q[s + k];
            if (s + k < tdi_q.size()) w[k] = tdi_q[s + k];
         end
         n_total++;
         if (c != 43 || n_tck - t0 != DR_W + 4)
            $display("FAIL rand%0d_timing got cyc=%0d ticks=%0d want 43 42", it, c, n_tck - t0);
         else n_pass++;
         n_total++;
         if (rsp_dr !== e || w !== dr || rsp_ir !== io || ir_in !== ir)
            $display("FAIL rand%0d_data got dr=%h tdi=%h ir=%b in=%b want %h %h %b %b",
                     it, rsp_dr, w, rsp_ir, ir_in, e, dr, io, ir);
         else n_pass++;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         rsp_ready = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int ups[$];
      int bad, k;
      mode = 2'd2;
      rsp_ready = 1'b1;
      cmd_ir = 2'b01;
      cmd_dr = 38'({$urandom, $urandom});
      cmd_valid = 1'b1;
      for (int i = 0; i < 180; i++) begin
         @(posedge clk); #1;
         if (vs_uir === 1'b1) ups.push_back(cyc_g);
      end
      cmd_valid = 1'b0;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      n_total++;
      if (ups.size() < 4) $display("FAIL b2b_count got %0d want >=4", ups.size());
      else n_pass++;
      bad = 0;
      for (int i = 1; i < ups.size(); i++)
         if (ups[i] - ups[i-1] != DR_W + 6) bad++;
      n_total++;
      if (bad != 0) $display("FAIL b2b_period got %0d bad gaps want 0 (period %0d)", bad, DR_W + 6);
      else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc_g);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_loopback();
      test_tdo_high();
      test_div3();
      test_rsp_hold();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
